regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: grants one ALU or load writeback per two cycles
// and keeps a destination-register busy scoreboard for the issue stage.
module regfile_write_arbiter #(
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [3:0]        alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [3:0]        mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   input  logic              issue_valid,
   input  logic [3:0]        issue_rd,
   output logic              issue_ready,
   input  logic [3:0]        q_ra,
   input  logic [3:0]        q_rb,
   output logic              busy_a,
   output logic              busy_b,
   output logic [3:0]        RW,
   output logic [DATA_W-1:0] BusW,
   output logic              EnW
);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t            state;
   logic [3:0]        starve_cnt;
   logic [15:0]       busy;
   logic              starved;
   logic              can_grant;
   logic              grant;
   logic [3:0]        win_rd;
   logic [DATA_W-1:0] win_data;
   logic [15:0]       busy_set;
   logic [15:0]       busy_clr;

   assign starved   = (starve_cnt == 4'(STARVE_MAX));
   assign can_grant = (state == IDLE) && !reset;

   // Loads win by default; a starved ALU takes the slot only while it is requesting.
   assign alu_ready   = can_grant && alu_valid && (!mem_valid || starved);
   assign mem_ready   = can_grant && mem_valid && !(alu_valid && starved);
   assign issue_ready = !reset && ((issue_rd == 4'd0) || !busy[issue_rd]);

   assign busy_a = busy[q_ra];
   assign busy_b = busy[q_rb];

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      win_rd   = mem_rd;
      win_data = mem_data;
      if (alu_ready) begin
         win_rd   = alu_rd;
         win_data = alu_data;
      end
      grant    = alu_ready || mem_ready;
      busy_clr = '0;
      busy_set = '0;
      if (grant && (win_rd != 4'd0))
         busy_clr = 16'(1) << win_rd;
      if (issue_valid && issue_ready && (issue_rd != 4'd0))
         busy_set = 16'(1) << issue_rd;
   end

   // NOTE: sequential state uses non-blocking assignments only; the async reset also
   // clears the registered write-port outputs so a write in flight is cancelled at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         busy       <= '0;
         EnW        <= 1'b0;
         RW         <= '0;
         BusW       <= '0;
      end else begin
         busy <= ((busy & ~busy_clr) | busy_set) & 16'hFFFE;

         if (!alu_valid || alu_ready)
            starve_cnt <= '0;
         else if (mem_ready && !starved)
            starve_cnt <= starve_cnt + 4'd1;

         case (state)
            IDLE: begin
               EnW <= 1'b0;
               if (grant) begin
                  state <= WRITE;
                  // rd==0 is consumed but never written
                  if (win_rd != 4'd0) begin
                     EnW  <= 1'b1;
                     RW   <= win_rd;
                     BusW <= win_data;
                  end
               end
            end
            WRITE: begin
               state <= IDLE;
               EnW   <= 1'b0;
            end
            default: begin
               state <= IDLE;
               EnW   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a cycle-level behavioural model
// compared on every falling edge, plus literal expectations per scenario.
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int SM = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          alu_valid = 1'b0;
   logic [3:0]    alu_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic          alu_ready;
   logic          mem_valid = 1'b0;
   logic [3:0]    mem_rd = '0;
   logic [DW-1:0] mem_data = '0;
   logic          mem_ready;
   logic          issue_valid = 1'b0;
   logic [3:0]    issue_rd = '0;
   logic          issue_ready;
   logic [3:0]    q_ra = '0;
   logic [3:0]    q_rb = '0;
   logic          busy_a, busy_b;
   logic [3:0]    RW;
   logic [DW-1:0] BusW;
   logic          EnW;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_write_arbiter #(.DATA_W(DW), .STARVE_MAX(SM)) dut (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .q_ra(q_ra), .q_rb(q_rb), .busy_a(busy_a), .busy_b(busy_b),
      .RW(RW), .BusW(BusW), .EnW(EnW)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit            m_write;    // a write slot is being consumed this cycle
   int            m_starve;   // ALU losses in a row
   bit            m_busy[16];
   bit            m_enw;
   logic [3:0]    m_rw;
   logic [DW-1:0] m_busw;

   function automatic bit exp_alu_ready();
      return !reset && !m_write && alu_valid && (!mem_valid || m_starve >= SM);
   endfunction

   function automatic bit exp_mem_ready();
      return !reset && !m_write && mem_valid && !(alu_valid && m_starve >= SM);
   endfunction

   function automatic bit exp_issue_ready();
      return !reset && (issue_rd == 0 || !m_busy[issue_rd]);
   endfunction

   always @(posedge clock or posedge reset) begin : model
      bit ga, gm, gi;
      if (reset) begin
         m_write  = 0;
         m_starve = 0;
         m_enw    = 0;
         m_rw     = '0;
         m_busw   = '0;
         for (int i = 0; i < 16; i++) m_busy[i] = 0;
      end else begin
         ga = exp_alu_ready();
         gm = exp_mem_ready();
         gi = issue_valid && exp_issue_ready();
         m_enw = 0;
         if (m_write) begin
            m_write = 0;
         end else if (ga || gm) begin
            m_write = 1;
            if ((ga ? alu_rd : mem_rd) != 0) begin
               m_enw  = 1;
               m_rw   = ga ? alu_rd : mem_rd;
               m_busw = ga ? alu_data : mem_data;
               m_busy[m_rw] = 0;
            end
         end
         if (gi && issue_rd != 0) m_busy[issue_rd] = 1;
         if (!alu_valid || ga) m_starve = 0;
         else if (gm) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
      end
   end

   always @(negedge clock) begin
      check("alu_ready",   alu_ready,   exp_alu_ready());
      check("mem_ready",   mem_ready,   exp_mem_ready());
      check("issue_ready", issue_ready, exp_issue_ready());
      check("busy_a",      busy_a,      m_busy[q_ra]);
      check("busy_b",      busy_b,      m_busy[q_rb]);
      check("EnW",         EnW,         m_enw);
      check("RW",          RW,          m_rw);
      check("BusW",        BusW,        m_busw);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   logic [7:0] got_seq;
   int         n_grants;
   int         n_pulses;
   int         n_double;
   logic       prev_enw;

   initial begin
      #1 reset = 1'b1;
      #11 reset = 1'b0;
      #1;
      check("rst_EnW", EnW, 0);
      check("rst_RW", RW, 0);
      check("rst_BusW", BusW, 0);

      // single load writeback
      tick();
      mem_valid = 1; mem_rd = 4'd5; mem_data = 32'hAAAA0001;
      #1 check("s1_mem_ready", mem_ready, 1);
      tick();
      mem_valid = 0;
      #1 check("s1_EnW", EnW, 1);
      check("s1_RW", RW, 5);
      check("s1_BusW", BusW, 32'hAAAA0001);
      check("s1_mem_ready_write", mem_ready, 0);
      tick();
      #1 check("s1_EnW_drop", EnW, 0);

      // both requesters held: MEM MEM MEM ALU repeating
      alu_valid = 1; alu_rd = 4'd1; alu_data = 32'h1111_0000;
      mem_valid = 1; mem_rd = 4'd2; mem_data = 32'h2222_0000;
      got_seq = '0; n_grants = 0; n_pulses = 0; n_double = 0; prev_enw = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (alu_ready || mem_ready) begin
            got_seq = {got_seq[6:0], alu_ready};
            n_grants++;
         end
         if (EnW) n_pulses++;
         if (EnW && prev_enw) n_double++;
         prev_enw = EnW;
         tick();
      end
      alu_valid = 0; mem_valid = 0;
      check("s2_grant_order", got_seq, 8'b0001_0001);
      check("s2_n_grants", n_grants, 8);
      check("s2_n_pulses", n_pulses, 8);
      check("s2_no_double", n_double, 0);

      // scoreboard: issue rd=7, re-issue blocked, ALU write clears
      issue_valid = 1; issue_rd = 4'd7; q_ra = 4'd7;
      #1 check("s3_issue_ready", issue_ready, 1);
      check("s3_busy_pre", busy_a, 0);
      tick();
      #1 check("s3_busy_set", busy_a, 1);
      check("s3_reissue_blocked", issue_ready, 0);
      issue_valid = 0;
      alu_valid = 1; alu_rd = 4'd7; alu_data = 32'h0000_0077;
      #1 check("s3_alu_ready", alu_ready, 1);
      tick();
      alu_valid = 0;
      #1 check("s3_EnW", EnW, 1);
      check("s3_RW", RW, 7);
      check("s3_busy_clr", busy_a, 0);
      check("s3_issue_ready_after", issue_ready, 1);
      tick();

      // ALU grant to r0 is dropped
      alu_valid = 1; alu_rd = 4'd0; alu_data = 32'hFFFF_FFFF; q_ra = 4'd0;
      #1 check("s4_alu_ready", alu_ready, 1);
      tick();
      alu_valid = 0;
      #1 check("s4_no_EnW", EnW, 0);
      check("s4_RW_hold", RW, 7);
      check("s4_BusW_hold", BusW, 32'h0000_0077);
      check("s4_busy_r0", busy_a, 0);
      tick();

      // issue rd=2 and write rd=9 at the same edge
      issue_valid = 1; issue_rd = 4'd9;
      #1 check("s5_issue9", issue_ready, 1);
      tick();
      issue_rd = 4'd2;
      mem_valid = 1; mem_rd = 4'd9; mem_data = 32'h0000_0099;
      #1 check("s5_mem_ready", mem_ready, 1);
      check("s5_issue2", issue_ready, 1);
      tick();
      issue_valid = 0; mem_valid = 0; q_ra = 4'd2; q_rb = 4'd9;
      #1 check("s5_busy2", busy_a, 1);
      check("s5_busy9", busy_b, 0);
      check("s5_EnW", EnW, 1);
      check("s5_RW", RW, 9);
      tick();

      // reset in the middle of a WRITE cycle
      mem_valid = 1; mem_rd = 4'd3; mem_data = 32'h0000_0033;
      tick();
      #1 check("s6_EnW_before", EnW, 1);
      check("s6_RW_before", RW, 3);
      #1 reset = 1'b1;
      #1 check("s6_EnW_rst", EnW, 0);
      check("s6_RW_rst", RW, 0);
      check("s6_BusW_rst", BusW, 0);
      check("s6_busy_rst", busy_a, 0);
      check("s6_mem_ready_rst", mem_ready, 0);
      check("s6_issue_ready_rst", issue_ready, 0);
      #1 reset = 1'b0;
      #1 check("s6_mem_ready_post", mem_ready, 1);
      tick();
      mem_valid = 0;
      #1 check("s6_EnW_post", EnW, 1);
      check("s6_RW_post", RW, 3);
      check("s6_BusW_post", BusW, 32'h0000_0033);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
